// File: rtl/arrayed_sig_scan_source.sv
// Register array loaded in parallel from a packed vector, streamed out one entry
// per accepted beat over valid/ready, then a one-cycle done pulse. SCAN_REVERSE_EN selects descending order.
module arrayed_sig_scan_source #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 2,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [DEPTH*WIDTH-1:0]   load_data,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

`ifdef SCAN_REVERSE_EN
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_LAST;
    localparam logic [ADDR_W-1:0] ADDR_END   = '0;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
        return a - ADDR_W'(1);
    endfunction
`else
    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_END   = ADDR_LAST;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction
`endif

    logic [WIDTH-1:0]  r_mem [DEPTH];
    state_t            r_state;
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic              w_valid_nxt;
    logic [WIDTH-1:0]  w_data_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_load_en;
    logic [ADDR_W-1:0] w_addr_step;

    assign w_addr_step = step_addr(r_addr);

    // Array storage: entry 0 lives in the most significant slice of load_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_load_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= load_data[(DEPTH-1-i)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load_en   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // A load in the same cycle as start takes priority; start is dropped.
                if (load) begin
                    w_load_en = 1'b1;
                end else if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_addr_nxt  = ADDR_FIRST;
                    w_data_nxt  = r_mem[ADDR_FIRST];
                end
            end
            ST_SCAN: begin
                if (r_valid && out_ready) begin
                    if (r_addr == ADDR_END) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_addr_nxt  = '0;
                    end else begin
                        w_addr_nxt = w_addr_step;
                        w_data_nxt = r_mem[w_addr_step];
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_addr_nxt  = '0;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_arrayed_sig_scan_source.sv
// Scoreboard bench for arrayed_sig_scan_source: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_arrayed_sig_scan_source;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 2;
    localparam int ADDR_W = 2;

`ifdef SCAN_REVERSE_EN
    localparam logic [1:0] FIRST_A = 2'd3;
    localparam logic [1:0] FIRST_D = 2'd0;
    localparam int         CYC_AT2 = 2;
`else
    localparam logic [1:0] FIRST_A = 2'd0;
    localparam logic [1:0] FIRST_D = 2'd3;
    localparam int         CYC_AT2 = 3;
`endif

    logic                   clk;
    logic                   rst;
    logic                   load;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic                   start;
    logic                   out_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    logic [ADDR_W+WIDTH-1:0] q[$];

    arrayed_sig_scan_source #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .start    (start),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_addr (out_addr),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected beats for an array holding d0..d3 at entries 0..3.
    task automatic expect_scan(input logic [1:0] d0, input logic [1:0] d1,
                               input logic [1:0] d2, input logic [1:0] d3);
        logic [1:0] d[4];
        d = '{d0, d1, d2, d3};
`ifdef SCAN_REVERSE_EN
        for (int i = 3; i >= 0; i--) q.push_back({2'(i), d[i]});
`else
        for (int i = 0; i < 4; i++) q.push_back({2'(i), d[i]});
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [3:0] b;
            n_beats++;
            if (q.size() == 0) begin
                check("beat_unexpected", {30'd0, out_addr}, 32'hFFFF_FFFF);
            end else begin
                b = q.pop_front();
                check("beat_addr", {30'd0, out_addr}, {30'd0, b[3:2]});
                check("beat_data", {30'd0, out_data}, {30'd0, b[1:0]});
            end
        end
    end

    task automatic do_load(input logic [7:0] v);
        @(posedge clk); #1;
        load = 1'b1; load_data = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts negedges until done is seen; checks the count and the DONE-cycle outputs.
    task automatic wait_done(input string name, input int exp_cyc);
        int c;
        bit found;
        c = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            c++;
            if (done) found = 1;
        end
        if (!found) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check(name, c, exp_cyc);
            check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
            check({name, "_busy"}, {31'd0, busy}, 32'd0);
            check({name, "_addr"}, {30'd0, out_addr}, 32'd0);
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
            check({name, "_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats0;
        rst = 1'b1; load = 1'b0; load_data = '0; start = 1'b0; out_ready = 1'b0;

        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {30'd0, out_addr}, 32'd0);
        check("rst_data", {30'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic scan, ready held high.
        do_load(8'b11_10_01_00);
        out_ready = 1'b1;
        expect_scan(2'd3, 2'd2, 2'd1, 2'd0);
        pulse_start();
        @(negedge clk);
        check("basic_lat_valid", {31'd0, out_valid}, 32'd1);
        check("basic_lat_busy", {31'd0, busy}, 32'd1);
        check("basic_lat_addr", {30'd0, out_addr}, {30'd0, FIRST_A});
        wait_done("basic_done_cyc", 4);
        @(negedge clk);
        check("basic_done_width", {31'd0, done}, 32'd0);
        check("basic_q_empty", q.size(), 0);

        // Back-to-back: new start on the cycle right after done.
        expect_scan(2'd3, 2'd2, 2'd1, 2'd0);
        pulse_start();
        wait_done("b2b_first_cyc", 5);
        expect_scan(2'd3, 2'd2, 2'd1, 2'd0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_lat_valid", {31'd0, out_valid}, 32'd1);
        wait_done("b2b_second_cyc", 4);
        check("b2b_q_empty", q.size(), 0);

        // Backpressure: first beat held for four cycles.
        out_ready = 1'b0;
        beats0 = n_beats;
        expect_scan(2'd3, 2'd2, 2'd1, 2'd0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_addr", {30'd0, out_addr}, {30'd0, FIRST_A});
            check("bp_hold_data", {30'd0, out_data}, {30'd0, FIRST_D});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hold4_addr", {30'd0, out_addr}, {30'd0, FIRST_A});
        check("bp_hold4_data", {30'd0, out_data}, {30'd0, FIRST_D});
        wait_done("bp_done_cyc", 4);
        check("bp_beat_count", n_beats - beats0, 4);
        check("bp_q_empty", q.size(), 0);

        // Load and start together in IDLE: load wins, no scan.
        @(posedge clk); #1;
        load = 1'b1; start = 1'b1; load_data = 8'h5A;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        check_idle("col_nostart", 3);

        // Load/start during SCAN are ignored.
        expect_scan(2'd1, 2'd1, 2'd2, 2'd2);
        pulse_start();
        @(negedge clk);
        @(posedge clk); #1;
        load = 1'b1; start = 1'b1; load_data = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        wait_done("col_done_cyc", 2);
        // Start during DONE is ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_idle("done_nostart", 3);
        expect_scan(2'd1, 2'd1, 2'd2, 2'd2);
        pulse_start();
        wait_done("col_rescan_cyc", 5);
        check("col_q_empty", q.size(), 0);

        // Asynchronous reset mid-scan at address 2.
        do_load(8'b11_10_01_00);
        expect_scan(2'd3, 2'd2, 2'd1, 2'd0);
        pulse_start();
        repeat (CYC_AT2) @(negedge clk);
        check("ar_pre_addr", {30'd0, out_addr}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_done", {31'd0, done}, 32'd0);
        check("ar_addr", {30'd0, out_addr}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        expect_scan(2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start();
        @(negedge clk);
        check("ar_post_valid", {31'd0, out_valid}, 32'd1);
        check("ar_post_data", {30'd0, out_data}, 32'd0);
        wait_done("ar_post_done_cyc", 4);

        @(negedge clk);
        check("final_q_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
